// File: rtl/fwd_pkg.sv
// Shared types and constants for the decode-stage forwarding scoreboard.
// Slots mirror the E..W producers still in flight.
package fwd_pkg;

    localparam int REG_AW  = 5;
    localparam int AVAIL_W = 4;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    localparam int STG_RF = 0;
    localparam int STG_E  = 1;
    localparam int STG_M  = 2;
    localparam int STG_W  = 3;

    typedef struct packed {
        logic               v;
        logic [REG_AW-1:0]  dst;
        logic [AVAIL_W-1:0] avail;
    } fwd_slot_t;

endpackage

// File: rtl/fwd_port_match.sv
// Youngest-match lookup for one decode read port.
// Yields the forwarding select and this port's stall request.
module fwd_port_match
    import fwd_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  fwd_slot_t [DEPTH:1]  slots,
    input  logic                 en,
    input  logic [REG_AW-1:0]    addr,
    input  logic [SEL_W-1:0]     need,
    output logic [SEL_W-1:0]     sel,
    output logic                 stall_req
);

    logic               hit;
    int                 hit_k;
    logic [AVAIL_W-1:0] hit_av;

    always_comb begin
        hit    = 1'b0;
        hit_k  = 0;
        hit_av = '0;
        // scan oldest to youngest so the youngest match is the one kept
        for (int k = DEPTH; k >= 1; k--) begin
            if (slots[k].v && slots[k].dst == addr) begin
                hit    = 1'b1;
                hit_k  = k;
                hit_av = slots[k].avail;
            end
        end
    end

    always_comb begin
        sel       = '0;
        stall_req = 1'b0;
        if (en && addr != REG_ZERO && hit) begin
            if (hit_k >= int'(hit_av)) begin
                sel = SEL_W'(hit_k);
            end else if (hit_k + int'(need) < int'(hit_av)) begin
                stall_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Decode-stage forwarding scoreboard: shift-register slots for E..W,
// per-port forwarding selects, global stall and saturating stall counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = $clog2(DEPTH + 1),
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [REG_AW-1:0]         issue_dst,
    input  logic [SEL_W-1:0]          issue_avail,
    input  logic                      flush,
    input  logic [NUM_RD-1:0]         rd_en,
    input  logic [REG_AW*NUM_RD-1:0]  rd_addr,
    input  logic [SEL_W*NUM_RD-1:0]   rd_need,
    output logic [SEL_W*NUM_RD-1:0]   fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    fwd_slot_t [DEPTH:1]       slots;
    fwd_slot_t                 head;
    logic [NUM_RD-1:0]         req;
    logic [SEL_W*NUM_RD-1:0]   sel_raw;

    always_comb begin
        head.v     = issue_valid & ~stall & ~flush & (issue_dst != REG_ZERO);
        head.dst   = issue_dst;
        head.avail = AVAIL_W'(issue_avail);
    end

    // slots always advance; a stall only turns the new entry into a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slots <= '0;
        end else begin
            slots[1] <= head;
            for (int k = 2; k <= DEPTH; k++) begin
                slots[k] <= slots[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        fwd_port_match #(
            .DEPTH (DEPTH),
            .SEL_W (SEL_W)
        ) u_match (
            .slots     (slots),
            .en        (rd_en[p]),
            .addr      (rd_addr[p*REG_AW +: REG_AW]),
            .need      (rd_need[p*SEL_W +: SEL_W]),
            .sel       (sel_raw[p*SEL_W +: SEL_W]),
            .stall_req (req[p])
        );
    end

    assign stall   = reset & (|req);
    assign fwd_sel = reset ? sel_raw : '0;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with a cycle-history reference model
// checked every cycle, plus literal expectations from the test plan.
module tb_fwd_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_dst;
    logic [1:0] issue_avail;
    logic       flush;
    logic [1:0] rd_en;
    logic [9:0] rd_addr;
    logic [3:0] rd_need;
    logic [3:0] fwd_sel;
    logic       stall;
    logic [3:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    fwd_scoreboard #(
        .NUM_RD (2),
        .DEPTH  (3),
        .CNT_W  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .issue_avail (issue_avail),
        .flush       (flush),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_need     (rd_need),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: remember what each cycle's issue recorded; the producer k
    // stages ahead of D is whatever was recorded k cycles ago.
    bit   e_v   [0:1023];
    int   e_dst [0:1023];
    int   e_av  [0:1023];
    int   cyc     = 0;
    int   floor_c = 0;
    int   cnt_m   = 0;
    bit   m_stall = 0;

    function automatic void model_port(input bit en, input int a, input int need,
                                       output int sel, output bit st);
        bit done;
        sel  = 0;
        st   = 0;
        done = 0;
        if (en && a != 0) begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = cyc - k;
                if (!done && c >= 0 && c >= floor_c) begin
                    if (e_v[c] && e_dst[c] == a) begin
                        done = 1;
                        if (k >= e_av[c]) sel = k;
                        else if (k + need < e_av[c]) st = 1;
                    end
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        int s0, s1;
        bit t0, t1;
        if (!reset) begin
            s0 = 0; s1 = 0; t0 = 0; t1 = 0;
            cnt_m = 0;
        end else begin
            model_port(rd_en[0], int'(rd_addr[4:0]), int'(rd_need[1:0]), s0, t0);
            model_port(rd_en[1], int'(rd_addr[9:5]), int'(rd_need[3:2]), s1, t1);
        end
        m_stall = t0 | t1;
        chk("model_sel0", int'(fwd_sel[1:0]), s0);
        chk("model_sel1", int'(fwd_sel[3:2]), s1);
        chk("model_stall", int'(stall), int'(m_stall));
        chk("model_cnt", int'(stall_cnt), cnt_m);
    end

    always @(posedge clk) begin
        if (!reset) begin
            floor_c = cyc + 1;
            cnt_m   = 0;
        end else begin
            e_v[cyc]   = issue_valid && !m_stall && !flush && issue_dst != 0;
            e_dst[cyc] = int'(issue_dst);
            e_av[cyc]  = int'(issue_avail);
            if (m_stall && cnt_m != 15) cnt_m++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic iss(input bit v, input int d, input int av, input bit fl);
        issue_valid = v;
        issue_dst   = 5'(d);
        issue_avail = 2'(av);
        flush       = fl;
    endtask

    task automatic rd(input int p, input bit en, input int a, input int need);
        rd_en[p]          = en;
        rd_addr[p*5 +: 5] = 5'(a);
        rd_need[p*2 +: 2] = 2'(need);
    endtask

    task automatic idle();
        iss(0, 0, 0, 0);
        rd(0, 0, 0, 0);
        rd(1, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        look();
        chk("rst_sel", int'(fwd_sel), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_cnt", int'(stall_cnt), 0);
        tick();
        reset = 1'b1;

        // jal $31 then jr $31
        iss(1, 31, 1, 0);
        tick();
        idle();
        rd(0, 1, 31, 0);
        look();
        chk("jr_e_sel", int'(fwd_sel[1:0]), 1);
        chk("jr_e_stall", int'(stall), 0);
        tick();
        look();
        chk("jr_m_sel", int'(fwd_sel[1:0]), 2);
        tick();
        idle();
        tick();

        // lw $8 then jr $8
        iss(1, 8, 3, 0);
        tick();
        idle();
        rd(0, 1, 8, 0);
        look();
        chk("lw_stall1", int'(stall), 1);
        chk("lw_sel1", int'(fwd_sel[1:0]), 0);
        tick();
        look();
        chk("lw_stall2", int'(stall), 1);
        tick();
        look();
        chk("lw_w_sel", int'(fwd_sel[1:0]), 3);
        chk("lw_w_stall", int'(stall), 0);
        chk("lw_cnt", int'(stall_cnt), 2);
        tick();
        look();
        chk("lw_retired", int'(fwd_sel[1:0]), 0);
        tick();
        idle();

        // addu $5 then addiu $5, port1 reads $5 at E
        iss(1, 5, 2, 0);
        tick();
        iss(1, 5, 2, 0);
        tick();
        idle();
        rd(1, 1, 5, 1);
        look();
        chk("young_sel1", int'(fwd_sel[3:2]), 0);
        chk("young_stall", int'(stall), 0);
        tick();
        idle();

        // writes to $0 are never tracked
        iss(1, 0, 1, 0);
        tick();
        idle();
        rd(0, 1, 0, 0);
        rd(1, 1, 0, 1);
        look();
        chk("zero_sel", int'(fwd_sel), 0);
        chk("zero_stall", int'(stall), 0);
        tick();
        idle();
        tick();
        tick();

        // flush coinciding with a stall
        iss(1, 8, 3, 0);
        tick();
        iss(1, 9, 2, 1);
        rd(0, 1, 8, 0);
        look();
        chk("fl_stall", int'(stall), 1);
        tick();
        idle();
        rd(1, 1, 9, 0);
        look();
        chk("fl_sel1", int'(fwd_sel[3:2]), 0);
        chk("fl_stall_after", int'(stall), 0);
        chk("fl_cnt", int'(stall_cnt), 3);
        tick();
        idle();

        // back-to-back loads feeding jr: counter saturates
        iss(1, 8, 3, 0);
        rd(0, 1, 8, 0);
        for (int i = 0; i < 30; i++) tick();
        look();
        chk("sat_cnt", int'(stall_cnt), 15);
        if (stall !== 1'b1) begin
            tick();
            look();
        end
        chk("sat_stall", int'(stall), 1);
        tick();
        reset = 1'b0;
        look();
        chk("mid_rst_stall", int'(stall), 0);
        chk("mid_rst_cnt", int'(stall_cnt), 0);
        chk("mid_rst_sel", int'(fwd_sel), 0);
        tick();
        reset = 1'b1;
        look();
        chk("post_rst_stall", int'(stall), 0);
        chk("post_rst_sel", int'(fwd_sel), 0);
        tick();
        idle();
        tick();
        look();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the jr-only forwarding logic.
- Tracks in-flight register writes in a shift-register scoreboard that mirrors the E..W pipeline stages.
- Serves NUM_RD decode-stage read ports (jr, branch, rs/rt operands). Each port gets a forwarding-source select; the block raises a global stall when a needed result is not produced in time.
- Sits in the decode stage, beside the hazard controller. Also keeps a saturating stall-cycle counter.

Parameters:
- NUM_RD, 2, number of decode read ports.
- DEPTH, 3, tracked stages after D (1=E, 2=M, 3=W).
- SEL_W, $clog2(DEPTH+1), width of each forwarding select.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  instruction in D writes a register.
- issue_dst  in  5  destination register of the D instruction.
- issue_avail  in  SEL_W  stage (1..DEPTH) at which that result becomes forwardable (jal=1, cal_r/cal_i=2, load=3).
- flush  in  1  kill the D instruction (bubble into E).
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  5*NUM_RD  per-port source register.
- rd_need  in  SEL_W*NUM_RD  per-port stage offset at which the operand is consumed (0=D for jr/branch, 1=E for ALU, 2=M for store data).
- fwd_sel  out  SEL_W*NUM_RD  0=register file, k=forward from stage k.
- stall  out  1  freeze PC/IF/D and insert a bubble into E.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Slot k (1..DEPTH) holds {v, dst, avail}. This is the producer currently in stage k.
- Reset (reset=0, asynchronous): all slot v=0, stall_cnt=0.
  - fwd_sel reads 0 while in reset; stall reads 0.
- Each rising edge, when reset=1:
  - Slot 1 is loaded with {issue_valid & ~stall & ~flush & (issue_dst!=0), issue_dst, issue_avail}.
  - Slot k+1 takes slot k.
  - Slot DEPTH retires and is dropped.
  - Stall never freezes slots 1..DEPTH; it only turns the slot-1 load into a bubble.
- issue_dst=0 is never recorded. A read of $0 always gives fwd_sel=0 and no stall.
- Per port p with rd_en[p]=1 and rd_addr!=0:
  - Find the youngest slot k (smallest k) with v=1 and dst==rd_addr. Older matches are ignored.
  - No match: fwd_sel=0, no stall contribution.
  - Match with k>=avail: fwd_sel=k.
  - Match with k<avail and k+rd_need>=avail: fwd_sel=0, no stall. A later stage forwards the value.
  - Match with k+rd_need<avail: fwd_sel=0, port stall request asserted.
- Output timing:
  - stall = OR of all port stall requests; purely combinational from the slots and current inputs, zero latency.
  - fwd_sel is combinational, same cycle.
- stall_cnt increments on each edge where stall=1 and saturates at all-ones.
- flush together with stall: a bubble is inserted, and stall is still counted.
- Two ports matching different slots are resolved independently.
- The slot DEPTH (W) value is forwarded. From the next cycle the register file supplies it.
- Reset asserted mid-operation clears all slots at once. The first cycle after release sees no hazards.

Decomposition:
- Package fwd_pkg:
  - REG_AW=5 and REG_ZERO.
  - Stage constants STG_RF=0, STG_E=1, STG_M=2, STG_W=3.
  - Typedef fwd_slot_t {v, dst, avail}.
- Sub-module fwd_port_match:
  - One instance per read port, generated NUM_RD times.
  - Youngest-match priority encoder over the slot vector.
  - Outputs sel and stall_req.

Test Plan:
- jal issued (dst=31, avail=1), next cycle jr $31 on port0 with need=0 -> fwd_sel[0]=1, stall=0. One cycle later (jal in M) -> fwd_sel[0]=2.
- lw $8 (avail=3) followed immediately by jr $8, need=0 -> stall=1 for 2 cycles with fwd_sel=0. Third cycle fwd_sel=3, stall=0, stall_cnt=2.
- addu $5 in M and addiu $5 in E, port1 reads $5 with need=1 -> youngest slot wins (E slot, avail=2, 1+1>=2): fwd_sel[1]=0, no stall. The M-slot value is not selected.
- issue_dst=0 with issue_valid=1, then read $0 -> fwd_sel=0, stall=0, no slot recorded.
- flush and stall both asserted while issuing dst=9; next cycle read $9 -> no match, fwd_sel=0. stall_cnt increments by 1.
- Stalls held for 2^CNT_W cycles with CNT_W=4 -> stall_cnt holds at 15. Then reset pulsed low mid-stall -> slots clear, stall_cnt=0, stall=0.
